results_receiver: RTL and testbench
===================================

Name: results_receiver

Overview:
- Inbound counterpart of the results sender. Accepts a framed stream of 32-bit CPU bus words and writes the contained DATA_WIDTH-bit values into the solver RAM through one write port.
- Frame layout: one element-count word, then N elements of 64-bit data, low half first then high half. When DATA_WIDTH=32, each element is one word.
- Fills the coefficient/initial-value region before the solver starts.

Parameters:
- ADDRESS_WIDTH, 13, RAM address width.
- DATA_WIDTH, 64, RAM word width; only 32 and 64 are legal.
- COUNT_ADDRESS, 1, RAM address that receives the element count.
- START_ADDRESS, 3, RAM address of element 0.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Receiving_Enable  input  1  start pulse; sampled only in IDLE.
- CPU_Bus  input  32  inbound data word.
- Bus_Valid  input  1  CPU_Bus holds a valid word this cycle.
- Busy  output  1  frame in progress.
- Done_Receiving  output  1  one-cycle pulse at frame end.
- RAM_Address  output  ADDRESS_WIDTH  write address.
- RAM_Data  output  DATA_WIDTH  write data.
- RAM_Write_Enable  output  1  write strobe, one cycle per write.
- Length_Error  output  1  sticky; count exceeded capacity.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; element counter, half register and count register cleared. A partially received element is discarded, not written.
- Words are consumed only when Bus_Valid=1. While Bus_Valid=0, the state holds (stall) and no write occurs.
- MAX_ELEMENTS = 2^ADDRESS_WIDTH - START_ADDRESS.
- IDLE:
  - Receiving_Enable=1 -> GET_COUNT, Busy=1.
  - Receiving_Enable=1 in any other state is ignored.
- GET_COUNT, on a valid word:
  - Latch N = CPU_Bus.
  - Next cycle: RAM_Write_Enable=1, RAM_Address=COUNT_ADDRESS, RAM_Data=N zero-extended.
  - N > MAX_ELEMENTS -> Length_Error=1 (sticky until reset or next start); go to DONE with no element writes.
  - N = 0 -> DONE.
  - Otherwise -> GET_LOW.
- GET_LOW (DATA_WIDTH=64), on a valid word: store it as the low half -> GET_HIGH.
- GET_HIGH, on a valid word:
  - Next cycle: RAM_Write_Enable=1, RAM_Address=START_ADDRESS+k, RAM_Data={CPU_Bus, low}. k is the element index.
  - Then k++; k=N-1 -> DONE, else -> GET_LOW.
- DATA_WIDTH=32: GET_LOW performs the write directly; GET_HIGH is unused.
- Latency: one cycle from accepting the final word of an element to its write strobe. Sustained throughput is one element per two valid words.
- DONE:
  - Done_Receiving=1 for exactly one cycle, aligned with the cycle after the last write strobe. For N=0 or an error, this is the cycle after the count write.
  - Busy=0 in the same cycle; next state IDLE.
- Length_Error clears on an accepted Receiving_Enable.
- Address arithmetic: START_ADDRESS+k is computed at ADDRESS_WIDTH+1 bits and truncated. Wrap cannot occur for legal N.
- RAM_Address and RAM_Data hold their last values when RAM_Write_Enable=0.

Optional Feature:
- Macro RESULTS_RECEIVER_CHECKSUM_EN.
- With the macro:
  - After the last element, a CHECK state consumes one more word, which must equal the XOR of the count word and every data word in the frame.
  - On mismatch, the sticky output Checksum_Error (1 bit) is set.
  - Done_Receiving is delayed until the checksum word is accepted.
- Without the macro: no CHECK state, no checksum accumulator, no Checksum_Error port.

Decomposition:
- Shared package holds:
  - state enum (IDLE, GET_COUNT, GET_LOW, GET_HIGH, CHECK, DONE);
  - COUNT_ADDRESS, START_ADDRESS and default widths, shared with the results sender so both agree on the memory map.
- Natural sub-module: word_assembler. It pairs two 32-bit halves into one DATA_WIDTH word with a half-select flag and is a pass-through for 32-bit.
- The FSM and the address counter stay in results_receiver.

Test Plan:
- Basic frame, DATA_WIDTH=64: pulse start, then words 2, 0x1, 0x0, 0xDEADBEEF, 0x12345678, all with Bus_Valid=1.
  - Writes: addr1<=2; addr3<=0x0000000000000001; addr4<=0x12345678DEADBEEF.
  - Done_Receiving pulses once, one cycle after the addr4 write.
- Stalls: the same frame with Bus_Valid toggling every other cycle -> identical writes and data, no extra strobes, Busy held high throughout.
- Boundary counts:
  - N=0 -> only addr1<=0, then Done.
  - N=MAX_ELEMENTS+1 (8190) -> addr1<=8190, Length_Error=1, no element writes.
- Reset mid-frame: assert RST after the low half of element 1.
  - Immediately: outputs 0 and state IDLE; element 1 is never written.
  - A new frame after reset is received correctly.
- Ignored start: Receiving_Enable pulsed during GET_HIGH -> no effect on the frame or its addresses.
- With RESULTS_RECEIVER_CHECKSUM_EN, N=1, data 0x5, 0x0:
  - Checksum word 0x4 -> Checksum_Error=0.
  - Checksum word 0x7 -> Checksum_Error=1.
  - Done_Receiving pulses only after the checksum word is accepted.

Source files
------------

// File: rtl/results_receiver_pkg.sv
// Shared memory map, widths and state encoding for the results receiver and sender.
package results_receiver_pkg;

    localparam int BUS_WIDTH             = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 13;
    localparam int DEFAULT_DATA_WIDTH    = 64;
    localparam int COUNT_ADDRESS         = 1;
    localparam int START_ADDRESS         = 3;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_LOW,
        GET_HIGH,
        CHECK,
        DONE
    } state_t;

    // Number of element slots between START_ADDRESS and the top of the RAM.
    function automatic logic [32:0] max_elements(input int address_width, input int start_address);
        return 33'((64'd1 << address_width) - 64'(start_address));
    endfunction

endpackage

// File: rtl/results_receiver_word_assembler.sv
// Pairs two bus words (low first) into one RAM word; 32-bit RAM words pass straight through.
module results_receiver_word_assembler
    import results_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  capture_low,
    input  logic [BUS_WIDTH-1:0]  word,
    output logic [DATA_WIDTH-1:0] assembled
);

    generate
        if (DATA_WIDTH == 64) begin : g_pair
            logic [BUS_WIDTH-1:0] low_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    low_q <= '0;
                end else if (capture_low) begin
                    low_q <= word;
                end
            end

            assign assembled = {word, low_q};
        end else begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = capture_low ^ CLK ^ RST;
            assign assembled   = word;
        end
    endgenerate

endmodule

// File: rtl/results_receiver.sv
// Receives a framed word stream (count, then elements) and writes it into the solver RAM.
// Optional checksum word after the last element: define RESULTS_RECEIVER_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for Receiving_Enable
// GET_COUNT | waiting for the element-count word
// GET_LOW   | waiting for the low half (or whole 32-bit element)
// GET_HIGH  | waiting for the high half; completes the element
// CHECK     | waiting for the checksum word (checksum build only)
// DONE      | pulse Done_Receiving, drop Busy, return to IDLE
module results_receiver
    import results_receiver_pkg::*;
#(
    parameter int ADDRESS_WIDTH = results_receiver_pkg::DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = results_receiver_pkg::DEFAULT_DATA_WIDTH,
    parameter int COUNT_ADDRESS = results_receiver_pkg::COUNT_ADDRESS,
    parameter int START_ADDRESS = results_receiver_pkg::START_ADDRESS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Receiving_Enable,
    input  logic [BUS_WIDTH-1:0]     CPU_Bus,
    input  logic                     Bus_Valid,
    output logic                     Busy,
    output logic                     Done_Receiving,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address,
    output logic [DATA_WIDTH-1:0]    RAM_Data,
    output logic                     RAM_Write_Enable,
    output logic                     Length_Error
`ifdef RESULTS_RECEIVER_CHECKSUM_EN
    ,
    output logic                     Checksum_Error
`endif
);

    localparam logic [32:0] MAX_ELEMENTS = max_elements(ADDRESS_WIDTH, START_ADDRESS);
    localparam logic [ADDRESS_WIDTH:0] START_EXT = (ADDRESS_WIDTH + 1)'(START_ADDRESS);
    localparam bit WIDE = (DATA_WIDTH == 64);
`ifdef RESULTS_RECEIVER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHECK;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t                state;
    logic [BUS_WIDTH-1:0]  count_q;
    logic [BUS_WIDTH-1:0]  elem_idx;
    logic [DATA_WIDTH-1:0] assembled;
    logic                  last_elem;

    assign last_elem = (elem_idx == count_q - 32'd1);

    results_receiver_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .CLK         (CLK),
        .RST         (RST),
        .capture_low (state == GET_LOW && Bus_Valid),
        .word        (CPU_Bus),
        .assembled   (assembled)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= IDLE;
            Busy             <= 1'b0;
            Done_Receiving   <= 1'b0;
            RAM_Address      <= '0;
            RAM_Data         <= '0;
            RAM_Write_Enable <= 1'b0;
            Length_Error     <= 1'b0;
            count_q          <= '0;
            elem_idx         <= '0;
        end else begin
            RAM_Write_Enable <= 1'b0;
            Done_Receiving   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Receiving_Enable) begin
                        state        <= GET_COUNT;
                        Busy         <= 1'b1;
                        Length_Error <= 1'b0;
                        elem_idx     <= '0;
                    end
                end
                GET_COUNT: begin
                    if (Bus_Valid) begin
                        count_q          <= CPU_Bus;
                        RAM_Write_Enable <= 1'b1;
                        RAM_Address      <= ADDRESS_WIDTH'(COUNT_ADDRESS);
                        RAM_Data         <= DATA_WIDTH'(CPU_Bus);
                        if ({1'b0, CPU_Bus} > MAX_ELEMENTS) begin
                            Length_Error <= 1'b1;
                            state        <= DONE;
                        end else if (CPU_Bus == '0) begin
                            state <= AFTER_LAST;
                        end else begin
                            state <= GET_LOW;
                        end
                    end
                end
                GET_LOW: begin
                    if (Bus_Valid) begin
                        if (WIDE) begin
                            state <= GET_HIGH;
                        end else begin
                            RAM_Write_Enable <= 1'b1;
                            RAM_Address      <= ADDRESS_WIDTH'(START_EXT + elem_idx[ADDRESS_WIDTH:0]);
                            RAM_Data         <= assembled;
                            elem_idx         <= elem_idx + 32'd1;
                            state            <= last_elem ? AFTER_LAST : GET_LOW;
                        end
                    end
                end
                GET_HIGH: begin
                    if (Bus_Valid) begin
                        RAM_Write_Enable <= 1'b1;
                        RAM_Address      <= ADDRESS_WIDTH'(START_EXT + elem_idx[ADDRESS_WIDTH:0]);
                        RAM_Data         <= assembled;
                        elem_idx         <= elem_idx + 32'd1;
                        state            <= last_elem ? AFTER_LAST : GET_LOW;
                    end
                end
`ifdef RESULTS_RECEIVER_CHECKSUM_EN
                CHECK: begin
                    if (Bus_Valid) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    Done_Receiving <= 1'b1;
                    Busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESULTS_RECEIVER_CHECKSUM_EN
    logic [BUS_WIDTH-1:0] csum_q;

    // Running XOR over the count word and every data word of the frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            csum_q         <= '0;
            Checksum_Error <= 1'b0;
        end else if (state == IDLE && Receiving_Enable) begin
            csum_q         <= '0;
            Checksum_Error <= 1'b0;
        end else if (Bus_Valid) begin
            if (state == GET_COUNT || state == GET_LOW || state == GET_HIGH) begin
                csum_q <= csum_q ^ CPU_Bus;
            end else if (state == CHECK && CPU_Bus != csum_q) begin
                Checksum_Error <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_results_receiver.sv
// Directed bench for results_receiver: framing, stalls, count boundaries, reset and ignored start.
module tb_results_receiver;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Receiving_Enable = 1'b0;
    logic [31:0] CPU_Bus = '0;
    logic        Bus_Valid = 1'b0;
    logic        Busy;
    logic        Done_Receiving;
    logic [12:0] RAM_Address;
    logic [63:0] RAM_Data;
    logic        RAM_Write_Enable;
    logic        Length_Error;
`ifdef RESULTS_RECEIVER_CHECKSUM_EN
    logic        Checksum_Error;
`endif

    int vectors = 0;
    int miscompares = 0;

    int          cyc = 0;
    int          wn = 0;
    int          dn = 0;
    int          dc = 0;
    logic [12:0] wa [16];
    logic [63:0] wd [16];
    int          wc [16];
    int          busy_low = 0;

    logic [31:0] fr [8];

    always #5 CLK = ~CLK;

    results_receiver dut (
        .CLK              (CLK),
        .RST              (RST),
        .Receiving_Enable (Receiving_Enable),
        .CPU_Bus          (CPU_Bus),
        .Bus_Valid        (Bus_Valid),
        .Busy             (Busy),
        .Done_Receiving   (Done_Receiving),
        .RAM_Address      (RAM_Address),
        .RAM_Data         (RAM_Data),
        .RAM_Write_Enable (RAM_Write_Enable),
        .Length_Error     (Length_Error)
`ifdef RESULTS_RECEIVER_CHECKSUM_EN
        ,
        .Checksum_Error   (Checksum_Error)
`endif
    );

    // Write/done recorder, sampled 1 ns after each rising edge.
    always begin
        @(posedge CLK);
        #1;
        cyc++;
        if (RAM_Write_Enable === 1'b1 && wn < 16) begin
            wa[wn] = RAM_Address;
            wd[wn] = RAM_Data;
            wc[wn] = cyc;
            wn++;
        end
        if (Done_Receiving === 1'b1) begin
            dn++;
            dc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic en, input logic v, input logic [31:0] w);
        @(negedge CLK);
        Receiving_Enable = en;
        Bus_Valid        = v;
        CPU_Bus          = w;
        @(posedge CLK);
        #1;
    endtask

    // Starts a frame and feeds n words; optional idle cycle before each word,
    // optional start pulse coinciding with word en_idx.
    task automatic send(input int n, input bit stall, input int en_idx);
        wn = 0;
        dn = 0;
        busy_low = 0;
        tick(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                tick(1'b0, 1'b0, 32'hFFFF_FFFF);
                if (Busy !== 1'b1) busy_low++;
            end
            tick(i == en_idx, 1'b1, fr[i]);
            if (Busy !== 1'b1) busy_low++;
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_basic(input string tag);
        chk({tag, ".nwrites"}, 64'(wn), 64'd3);
        chk({tag, ".a0"}, 64'(wa[0]), 64'd1);
        chk({tag, ".d0"}, wd[0], 64'd2);
        chk({tag, ".a1"}, 64'(wa[1]), 64'd3);
        chk({tag, ".d1"}, wd[1], 64'h0000_0000_0000_0001);
        chk({tag, ".a2"}, 64'(wa[2]), 64'd4);
        chk({tag, ".d2"}, wd[2], 64'h1234_5678_DEAD_BEEF);
        chk({tag, ".ndone"}, 64'(dn), 64'd1);
        chk({tag, ".done_align"}, 64'(dc), 64'(wc[2] + 1));
        chk({tag, ".busy_end"}, 64'(Busy), 64'd0);
    endtask

    task automatic load_basic();
        fr[0] = 32'd2;
        fr[1] = 32'h1;
        fr[2] = 32'h0;
        fr[3] = 32'hDEAD_BEEF;
        fr[4] = 32'h1234_5678;
    endtask

    initial begin
        #23;
        RST = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        chk("rst.busy", 64'(Busy), 64'd0);
        chk("rst.we", 64'(RAM_Write_Enable), 64'd0);
        chk("rst.done", 64'(Done_Receiving), 64'd0);
        chk("rst.addr", 64'(RAM_Address), 64'd0);
        chk("rst.data", RAM_Data, 64'd0);
        chk("rst.lerr", 64'(Length_Error), 64'd0);

        load_basic();
        send(5, 1'b0, -1);
        check_basic("basic");
        chk("basic.addr_hold", 64'(RAM_Address), 64'd4);
        chk("basic.data_hold", RAM_Data, 64'h1234_5678_DEAD_BEEF);

        send(5, 1'b1, -1);
        check_basic("stall");
        chk("stall.busy_held", 64'(busy_low), 64'd0);

        send(5, 1'b0, 2);
        check_basic("ign_start");
        chk("ign_start.idle_after", 64'(Busy), 64'd0);

        fr[0] = 32'd8190;
        send(1, 1'b0, -1);
        chk("over.nwrites", 64'(wn), 64'd1);
        chk("over.a0", 64'(wa[0]), 64'd1);
        chk("over.d0", wd[0], 64'd8190);
        chk("over.lerr", 64'(Length_Error), 64'd1);
        chk("over.ndone", 64'(dn), 64'd1);
        chk("over.done_align", 64'(dc), 64'(wc[0] + 1));

        fr[0] = 32'd0;
        send(1, 1'b0, -1);
        chk("zero.nwrites", 64'(wn), 64'd1);
        chk("zero.a0", 64'(wa[0]), 64'd1);
        chk("zero.d0", wd[0], 64'd0);
        chk("zero.lerr_cleared", 64'(Length_Error), 64'd0);
        chk("zero.ndone", 64'(dn), 64'd1);
        chk("zero.done_align", 64'(dc), 64'(wc[0] + 1));

        // Largest legal count, then reset after the low half of element 1.
        wn = 0;
        dn = 0;
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'd8189);
        tick(1'b0, 1'b1, 32'hAAAA_0001);
        tick(1'b0, 1'b1, 32'hBBBB_0002);
        tick(1'b0, 1'b1, 32'hCCCC_0003);
        chk("max.lerr", 64'(Length_Error), 64'd0);
        chk("max.elem0_addr", 64'(wa[1]), 64'd3);
        chk("max.elem0_data", wd[1], 64'hBBBB_0002_AAAA_0001);
        #2;
        RST = 1'b1;
        #1;
        chk("mrst.busy", 64'(Busy), 64'd0);
        chk("mrst.we", 64'(RAM_Write_Enable), 64'd0);
        chk("mrst.addr", 64'(RAM_Address), 64'd0);
        chk("mrst.data", RAM_Data, 64'd0);
        chk("mrst.done", 64'(Done_Receiving), 64'd0);
        RST = 1'b0;
        tick(1'b0, 1'b1, 32'hDDDD_0004);
        tick(1'b0, 1'b0, 32'h0);
        chk("mrst.nwrites", 64'(wn), 64'd2);
        chk("mrst.idle", 64'(Busy), 64'd0);
        load_basic();
        send(5, 1'b0, -1);
        check_basic("post_rst");

`ifdef RESULTS_RECEIVER_CHECKSUM_EN
        fr[0] = 32'd1;
        fr[1] = 32'h5;
        fr[2] = 32'h0;
        fr[3] = 32'h4;
        send(4, 1'b0, -1);
        chk("csum_ok.err", 64'(Checksum_Error), 64'd0);
        chk("csum_ok.d1", wd[1], 64'h0000_0000_0000_0005);
        chk("csum_ok.ndone", 64'(dn), 64'd1);
        chk("csum_ok.done_align", 64'(dc), 64'(wc[1] + 2));
        fr[3] = 32'h7;
        send(4, 1'b0, -1);
        chk("csum_bad.err", 64'(Checksum_Error), 64'd1);
        chk("csum_bad.ndone", 64'(dn), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
